// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel timer: mode encodings, register
// offsets and CTRL bit positions.
package timer_pkg;

  typedef enum logic [1:0] {
    MODE_ONESHOT  = 2'd0,
    MODE_PERIODIC = 2'd1,
    MODE_SQUARE   = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_e;

  localparam logic [1:0] REG_COUNT  = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_LOAD   = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IRQ_EN  = 3;
  localparam int CTRL_CASCADE = 4;
  localparam int CTRL_PS_LO   = 5;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: LOAD/COUNT/CTRL, prescaler, sticky flag and output.
// Cascade ticking is only built when TIMER_CASCADE_EN is defined.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CW          = 32,
  parameter int PSW         = 8,
  parameter bit HAS_CASCADE = 1'b0
) (
  input  logic          clk,
  input  logic          RSTN,
  input  logic          we_load,
  input  logic          we_ctrl,
  input  logic          we_status,
  input  logic [CW-1:0] wdata,
  input  logic          cascade_tick,
  output logic [CW-1:0] count,
  output logic [CW-1:0] load,
  output logic [CW-1:0] ctrl,
  output logic          flag,
  output logic          irq_en,
  output logic          out,
  output logic          evt
);

  logic           en;
  mode_e          mode;
  logic [PSW-1:0] prescale;
  logic [PSW-1:0] ps_cnt;
  logic           casc;
  logic           ps_wrap;
  logic           tick;

  assign ps_wrap = (ps_cnt == prescale);

`ifdef TIMER_CASCADE_EN
  if (HAS_CASCADE) begin : g_casc
    always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN)        casc <= 1'b0;
      else if (we_ctrl) casc <= wdata[CTRL_CASCADE];
    end
  end else begin : g_nocasc
    logic unused_cascade;
    assign unused_cascade = cascade_tick;
    assign casc = 1'b0;
  end
  assign tick = en && (casc ? cascade_tick : ps_wrap);
`else
  logic unused_cascade;
  assign unused_cascade = cascade_tick & HAS_CASCADE;
  assign casc = 1'b0;
  assign tick = en && ps_wrap;
`endif

  // A LOAD write in the same cycle overrides the event entirely.
  assign evt  = tick && (count == CW'(1)) && !we_load;
  assign ctrl = CW'({prescale, casc, irq_en, mode, en});

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      en       <= 1'b0;
      mode     <= MODE_ONESHOT;
      irq_en   <= 1'b0;
      prescale <= '0;
      flag     <= 1'b0;
    end else begin
      if (we_ctrl) begin
        en       <= wdata[CTRL_EN];
        mode     <= mode_e'(wdata[CTRL_MODE_HI:CTRL_MODE_LO]);
        irq_en   <= wdata[CTRL_IRQ_EN];
        prescale <= wdata[CTRL_PS_LO +: PSW];
      end else if (evt && mode != MODE_PERIODIC && mode != MODE_SQUARE) begin
        en <= 1'b0;
      end
      if (evt)                         flag <= 1'b1;
      else if (we_status && wdata[0])  flag <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      load   <= '0;
      count  <= '0;
      ps_cnt <= '0;
      out    <= 1'b0;
    end else if (we_load) begin
      load   <= wdata;
      count  <= wdata;
      ps_cnt <= '0;
      out    <= 1'b0;
    end else begin
      // Periodic pulse lasts one cycle; an event below re-asserts it.
      if (mode == MODE_PERIODIC) out <= 1'b0;
      if (en) ps_cnt <= ps_wrap ? '0 : ps_cnt + 1'b1;
      if (tick && count > CW'(1)) count <= count - 1'b1;
      if (evt) begin
        case (mode)
          MODE_PERIODIC: begin count <= load; out <= 1'b1; end
          MODE_SQUARE:   begin count <= load; out <= ~out; end
          default:       begin count <= '0;   out <= 1'b1; end
        endcase
      end
    end
  end

endmodule

// File: rtl/timer_nch.sv
// Multi-channel programmable timer on the MIO bus: write decode, readback mux,
// registered irq. Optional channel cascading via TIMER_CASCADE_EN.
module timer_nch
  import timer_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 32,
  parameter int PSW = 8
) (
  input  logic                    clk,
  input  logic                    RSTN,
  input  logic                    we,
  input  logic [$clog2(NCH)+1:0]  addr,
  input  logic [CW-1:0]           wdata,
  output logic [CW-1:0]           rdata,
  output logic [NCH-1:0]          counter_out,
  output logic                    irq
);

  localparam int AW = $clog2(NCH) + 2;

  logic [AW-1:0]  chan;
  logic [1:0]     rsel;
  logic [NCH-1:0] evt;
  logic [NCH-1:0] casc_in;
  logic [NCH-1:0] flag;
  logic [NCH-1:0] irq_en;
  logic [CW-1:0]  count [NCH];
  logic [CW-1:0]  load  [NCH];
  logic [CW-1:0]  ctrl  [NCH];

  assign rsel    = addr[1:0];
  assign chan    = addr >> 2;
  assign casc_in = evt << 1;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic sel;
    assign sel = we && (chan == AW'(i));

    timer_channel #(
      .CW         (CW),
      .PSW        (PSW),
      .HAS_CASCADE(i > 0)
    ) u_ch (
      .clk         (clk),
      .RSTN        (RSTN),
      .we_load     (sel && rsel == REG_LOAD),
      .we_ctrl     (sel && rsel == REG_CTRL),
      .we_status   (sel && rsel == REG_STATUS),
      .wdata       (wdata),
      .cascade_tick(casc_in[i]),
      .count       (count[i]),
      .load        (load[i]),
      .ctrl        (ctrl[i]),
      .flag        (flag[i]),
      .irq_en      (irq_en[i]),
      .out         (counter_out[i]),
      .evt         (evt[i])
    );
  end

  // Channel indices with no instance fall through to zero.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (chan == AW'(i)) begin
        case (rsel)
          REG_COUNT:  rdata = count[i];
          REG_CTRL:   rdata = ctrl[i];
          REG_STATUS: rdata = CW'(flag[i]);
          default:    rdata = load[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) irq <= 1'b0;
    else       irq <= |(flag & irq_en);
  end

endmodule

// File: tb/tb_timer_nch.sv
// Scoreboard bench for timer_nch (3 channels so one channel index is unused).
module tb_timer_nch;
  import timer_pkg::*;

  localparam int NCH = 3;
  localparam int CW  = 32;
  localparam int PSW = 8;
  localparam int AW  = $clog2(NCH) + 2;

  localparam int SIG_OUT = 0;
  localparam int SIG_IRQ = 1;
  localparam int SIG_RD  = 2;

  logic           clk = 1'b0;
  logic           RSTN;
  logic           we;
  logic [AW-1:0]  addr;
  logic [CW-1:0]  wdata;
  logic [CW-1:0]  rdata;
  logic [NCH-1:0] counter_out;
  logic           irq;

  timer_nch #(.NCH(NCH), .CW(CW), .PSW(PSW)) dut (
    .clk        (clk),
    .RSTN       (RSTN),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .counter_out(counter_out),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          sig;
    int          idx;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, expv, cyc);
    else              n_pass++;
  endtask

  function automatic logic [31:0] obs_of(input int sig, input int idx);
    case (sig)
      SIG_OUT: return 32'(counter_out[idx]);
      SIG_IRQ: return 32'(irq);
      default: return rdata;
    endcase
  endfunction

  task automatic push(input int c, input int sig, input int idx, input logic [31:0] v,
                      input string tag);
    exp_t e;
    e.cyc = c; e.sig = sig; e.idx = idx; e.val = v; e.tag = tag;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check(sb[i].tag, obs_of(sb[i].sig, sb[i].idx), sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic wr(input int ch, input logic [1:0] r, input logic [31:0] d);
    we    = 1'b1;
    addr  = AW'(ch * 4 + int'(r));
    wdata = d;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic rd(input int ch, input logic [1:0] r, input logic [31:0] v, input string tag);
    addr = AW'(ch * 4 + int'(r));
    push(cyc, SIG_RD, 0, v, tag);
    @(posedge clk); #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, checks %0d", n_chk);
    $fatal(1);
  end

  initial begin
    int w;
    int x;
    RSTN = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", 32'(counter_out), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    RSTN = 1'b1;
    @(posedge clk); #1;

    // Periodic, ch0 LOAD=5, prescale 0
    wr(0, REG_LOAD, 5);
    wr(0, REG_CTRL, 32'h3);
    w = cyc;
    for (int k = 1; k <= 15; k++) push(w + k, SIG_OUT, 0, 32'((k % 5) == 0), "per_out0");
    rd(0, REG_STATUS, 0, "per_flag_pre");
    wait_to(w + 16);
    rd(0, REG_STATUS, 1, "per_flag_post");
    wr(0, REG_CTRL, 0);

    // One-shot, ch1 LOAD=3, PRESCALE=3, irq_en
    wr(1, REG_LOAD, 3);
    wr(1, REG_CTRL, 32'h1 | 32'h8 | (32'd3 << 5));
    w = cyc;
    push(w + 11, SIG_OUT, 1, 0, "os_out_pre");
    push(w + 12, SIG_OUT, 1, 1, "os_out_evt");
    push(w + 20, SIG_OUT, 1, 1, "os_out_held");
    push(w + 12, SIG_IRQ, 0, 0, "os_irq_lag");
    push(w + 13, SIG_IRQ, 0, 1, "os_irq_set");
    wait_to(w + 21);
    rd(1, REG_CTRL, 32'h8 | (32'd3 << 5), "os_ctrl_en_clr");
    rd(1, REG_COUNT, 0, "os_count");
    rd(1, REG_LOAD, 3, "os_load");
    x = cyc + 1;
    push(x, SIG_IRQ, 0, 1, "os_irq_w1c_lag");
    push(x + 1, SIG_IRQ, 0, 0, "os_irq_w1c_clr");
    wr(1, REG_STATUS, 1);
    rd(1, REG_STATUS, 0, "os_flag_w1c");

    // Square, ch2 LOAD=4, then disable mid-cycle
    wr(2, REG_LOAD, 4);
    wr(2, REG_CTRL, 32'h5);
    w = cyc;
    for (int k = 1; k <= 13; k++) push(w + k, SIG_OUT, 2, 32'((k >> 2) & 1), "sq_out2");
    push(w + 16, SIG_OUT, 2, 1, "sq_frozen_out");
    push(w + 20, SIG_OUT, 2, 1, "sq_frozen_out");
    push(w + 24, SIG_OUT, 2, 1, "sq_frozen_out");
    wait_to(w + 13);
    wr(2, REG_CTRL, 32'h4);
    wait_to(w + 25);
    rd(2, REG_COUNT, 2, "sq_frozen_count");
    wr(2, REG_COUNT, 77);
    rd(2, REG_COUNT, 2, "count_write_ignored");
    rd(2, REG_CTRL, 32'h4, "sq_ctrl");

    // Collisions on ch0
    wr(0, REG_LOAD, 5);
    wr(0, REG_STATUS, 1);
    wr(0, REG_CTRL, 32'h3);
    w = cyc;
    wait_to(w + 4);
    wr(0, REG_STATUS, 1);
    rd(0, REG_STATUS, 1, "col_set_wins");
    wr(0, REG_STATUS, 1);
    rd(0, REG_STATUS, 0, "col_flag_cleared");
    wait_to(w + 9);
    push(w + 10, SIG_OUT, 0, 0, "col_load_no_pulse");
    wr(0, REG_LOAD, 9);
    rd(0, REG_COUNT, 9, "col_load_count");
    rd(0, REG_STATUS, 0, "col_load_no_flag");
    wr(0, REG_CTRL, 0);

    // Asynchronous reset mid-count
    wr(0, REG_LOAD, 2);
    wr(0, REG_CTRL, 32'h1 | 32'h2 | 32'h8);
    w = cyc;
    push(w + 2, SIG_IRQ, 0, 0, "rst_irq_lag");
    push(w + 3, SIG_IRQ, 0, 1, "rst_irq_set");
    wait_to(w + 4);
    check("pre_rst_out", 32'(counter_out), 32'h7);
    RSTN = 1'b0;
    #1;
    check("async_rst_out", 32'(counter_out), 32'h0);
    check("async_rst_irq", 32'(irq), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    RSTN = 1'b1;
    @(posedge clk); #1;
    rd(2, REG_COUNT, 0, "post_rst_count");
    rd(2, REG_CTRL, 0, "post_rst_ctrl");
    rd(1, REG_LOAD, 0, "post_rst_load");
    rd(0, REG_STATUS, 0, "post_rst_flag");

    // LOAD=0 while enabled: never an event
    wr(0, REG_CTRL, 32'h1 | 32'h2 | 32'h8);
    w = cyc;
    for (int k = 1; k <= 10; k++) begin
      push(w + 10 * k, SIG_OUT, 0, 0, "zero_load_out");
      push(w + 10 * k, SIG_IRQ, 0, 0, "zero_load_irq");
    end
    wait_to(w + 101);
    rd(0, REG_STATUS, 0, "zero_load_flag");
    rd(0, REG_COUNT, 0, "zero_load_count");

    // Unused channel index
    wr(3, REG_LOAD, 55);
    rd(3, REG_LOAD, 0, "unused_ch_load");
    rd(3, REG_CTRL, 0, "unused_ch_ctrl");
    rd(0, REG_CTRL, 32'hb, "used_ch_ctrl");

`ifdef TIMER_CASCADE_EN
    wr(1, REG_LOAD, 3);
    wr(1, REG_CTRL, 32'h11);
    wr(0, REG_LOAD, 10);
    wr(0, REG_CTRL, 32'h3);
    w = cyc;
    push(w + 29, SIG_OUT, 1, 0, "casc_out_pre");
    push(w + 30, SIG_OUT, 1, 1, "casc_out_evt");
    wait_to(w + 31);
    rd(1, REG_CTRL, 32'h10, "casc_ctrl");
    rd(0, REG_CTRL, 32'h3, "casc_ch0_no_casc");
`endif

    @(posedge clk); #1;
    check("sb_drain", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/timer_nch.md
Name: timer_nch

Overview:
- Parametrised multi-channel programmable timer/counter; successor to the fixed 3-channel counter peripheral on the MIO bus.
- Generalises channel count, counter width and prescaler width.
- Adds per-channel modes, sticky event flags, a masked interrupt output and readback of all registers.
- Sits behind the MIO bus decoder. Its irq drives the CPU INT input; counter_out drives MIO status bits.

Parameters:
NCH, 4, number of independent channels (1..8)
CW, 32, counter/load/data width (must be >= PSW+5)
PSW, 8, prescaler field width; divide ratio = PRESCALE+1

Ports:
clk  input  1  single system clock; all state on rising edge
RSTN  input  1  asynchronous active-low reset
we  input  1  bus write strobe, one-cycle
addr  input  $clog2(NCH)+2  {channel, reg}; reg 0=COUNT, 1=CTRL, 2=STATUS, 3=LOAD
wdata  input  CW  bus write data
rdata  output  CW  combinational readback of the addressed register
counter_out  output  NCH  per-channel output (pulse or square, per mode)
irq  output  1  OR over channels of (flag & irq_en)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on RSTN.
- Reset values: all LOAD, COUNT, CTRL and prescaler registers = 0; flags = 0; counter_out = 0; irq = 0.
- CTRL bit fields:
  - [0] enable
  - [2:1] mode: 0 one-shot, 1 periodic, 2 square, 3 reserved (treated as one-shot)
  - [3] irq_en
  - [4] cascade (optional feature only; reads 0 otherwise)
  - [PSW+4:5] PRESCALE
- Write LOAD: LOAD and COUNT both take wdata; prescaler cleared; counter_out cleared. Takes effect the next cycle.
- Write CTRL: takes effect next cycle. Clearing enable freezes COUNT and the prescaler; counter_out holds its value.
- Write STATUS: W1C. wdata[0] clears the flag of the addressed channel.
- Tick: while enabled, the prescaler counts 0..PRESCALE. On reaching PRESCALE it wraps to 0 and issues one tick. With PRESCALE=0, a tick occurs every cycle.
- On a tick with COUNT>1: COUNT decrements.
- On a tick with COUNT==1 (event):
  - one-shot: COUNT->0, enable cleared by hardware, counter_out->1 and held until next LOAD write.
  - periodic: COUNT->LOAD, counter_out high for exactly 1 cycle.
  - square: COUNT->LOAD, counter_out toggles.
  - Every mode sets the flag.
- COUNT==0 while enabled (LOAD=0): no decrement, no events; counter_out stays 0.
- Event on the same cycle as a STATUS W1C of that channel: the set wins and the flag stays 1.
- LOAD write on the same cycle as an event: the LOAD write wins, and no flag is set that cycle.
- rdata, STATUS register: flag in bit 0, zero-extended.
- rdata, CTRL register: hardware-cleared enable is visible.
- rdata, unused channel index (>=NCH): 0.
- Writes to reg 0 (COUNT) are ignored.
- irq is registered and updates the cycle after a flag changes.
- Asynchronous reset mid-count: all state returns to reset values immediately; no event is emitted.

Optional Feature:
Macro TIMER_CASCADE_EN.
- Defined: CTRL[4] is writable. When channel i>0 has cascade=1, it ignores its own prescaler and ticks once per event of channel i-1. Channel 0 cascade bit reads 0. This builds a 2*CW-bit timer from channels 0 and 1.
- Undefined: CTRL[4] is read-as-zero and write-ignored, and no cascade logic is synthesised.

Decomposition:
- Shared package timer_pkg holds:
  - the mode encodings (MODE_ONESHOT, MODE_PERIODIC, MODE_SQUARE)
  - register offsets REG_COUNT/REG_CTRL/REG_STATUS/REG_LOAD
  - CTRL bit positions
- Sub-module timer_channel holds per-channel state: LOAD, COUNT, CTRL, prescaler, flag and output. It exposes an event output and a cascade tick input.
- timer_nch instantiates NCH copies in a generate loop, decodes writes, muxes rdata, and reduces irq.

Test Plan:
- Periodic: ch0 LOAD=5, CTRL=enable|mode1|PRESCALE=0 -> counter_out[0] pulses 1 cycle every 5 clks; flag=1 after first event.
- One-shot with prescale: ch1 LOAD=3, PRESCALE=3, irq_en -> single event at 12 clks; CTRL readback enable=0; irq=1 the next cycle; W1C STATUS -> irq=0.
- Square: ch2 LOAD=4, mode2 -> counter_out[2] period 8 clks, 50% duty; disable mid-cycle -> output and COUNT frozen.
- Collision: W1C on the exact event cycle -> flag remains 1. LOAD write on the event cycle -> COUNT=new LOAD, flag unchanged.
- Reset and edge cases: RSTN low mid-count -> all outputs 0 immediately. LOAD=0 enabled -> no events over 100 clks. Read addr with channel>=NCH -> 0.
- With TIMER_CASCADE_EN: ch0 periodic LOAD=10, ch1 cascade LOAD=3 one-shot -> ch1 event at clk 30.
